aes_block_unpacker: RTL
=======================

# aes_block_unpacker

Read-side drain engine for the AES output block FIFO. Pops 128-bit result blocks from a show-ahead synchronous FIFO and streams each one to the host as a sequence of narrower words over a valid/ready interface, most-significant word first. Sits between the cipher core's output FIFO and the host read port. Sustains one word per cycle, including back-to-back blocks.

## Interface

- `wbits`, 128, FIFO block width; must be an integer multiple of `obits`.
- `obits`, 32, host word width.
- `N` (derived, localparam) = `wbits/obits`; must be ≥ 2.

- `clock` in 1: single clock; all logic is on the rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `fifo_empty` in 1: FIFO empty flag.
- `fifo_rdata` in `wbits`: FIFO head entry; valid whenever `!fifo_empty` (show-ahead).
- `fifo_ren` out 1: pop strobe (combinational).
- `out_valid` out 1: host word valid.
- `out_ready` in 1: host accepts the word.
- `out_data` out `obits`: host word.
- `out_last` out 1: the current word is the final word of the block.
- `busy` out 1: a block is held, i.e. the FSM is in SEND.

## Operation

- Internal state:
  - `state` ∈ {IDLE, SEND}.
  - Shift register `shreg[wbits]`.
  - Word counter `cnt[$clog2(N)]`.
- IDLE:
  - `fifo_ren = !fifo_empty`.
  - On a pop: `shreg <= fifo_rdata`, `cnt <= 0`, go to SEND.
- SEND:
  - `out_valid = 1`.
  - `out_data = shreg[wbits-1 -: obits]`.
  - `out_last = (cnt == N-1)`.
- Handshake occurs when `out_valid & out_ready`. On a handshake with `cnt < N-1`:
  - `shreg <= shreg << obits`.
  - `cnt <= cnt + 1`.
- On a handshake with `cnt == N-1`:
  - If `!fifo_empty`: `fifo_ren = 1`, reload `shreg` from `fifo_rdata`, `cnt <= 0`, stay in SEND. This is the back-to-back case with no bubble.
  - Otherwise go to IDLE.
- `fifo_ren` equation: `(IDLE & !fifo_empty) | (SEND & handshake & out_last & !fifo_empty)`. It never asserts when `fifo_empty` is high.
- Valid/ready rules:
  - Once `out_valid` rises, `out_data` and `out_last` stay stable until the handshake.
  - `out_valid` never drops without a handshake.
  - `out_valid` does not depend combinationally on `out_ready`.
- `out_ready` asserted while `out_valid` is low has no effect.
- `cnt` never exceeds N-1 and does not wrap outside the reload path.

## Timing

- Reset values:
  - `state` = IDLE, `shreg` = 0, `cnt` = 0.
  - `out_valid` = 0, `out_last` = 0, `out_data` = 0, `busy` = 0.
  - `fifo_ren` = 0 while `resetn` is low.
- An asynchronous reset mid-block discards the held block and any remaining words. Entries already popped are lost; entries still in the FIFO are untouched by this block.
- Latency: a block present at the FIFO head in cycle t gives `out_valid` = 1 in cycle t+1.
- Throughput: with `out_ready` held high, a block drains in N cycles. Consecutive blocks produce a continuous `out_valid` with no idle cycle.
- `fifo_empty` rising in the same cycle as the last handshake sends the FSM to IDLE. A later arrival is popped one cycle after it appears.

## Configuration

- Macro `AES_UNPACK_BSWAP_EN`.
- When defined: `out_data` is byte-reversed within each `obits` word (little-endian host). Requires `obits % 8 == 0`. Word order is unchanged.
- When undefined: `out_data` is the word exactly as stored (big-endian, AES state byte order).
- The swap is purely combinational on the output. Latency and handshake are identical in both builds.

## Structure

- Shared package `aes_pkg`:
  - `AES_BLOCK_BITS` = 128.
  - `AES_WORD_BITS` = 32.
  - Enum `unpack_state_t` {IDLE, SEND}.
  - Function `aes_bswap(word)` used under the macro.
- No sub-module. The FSM, counter and shift register live in one module. The FIFO is instantiated by the parent.

## Test plan

- Reset, then push one block 0x00112233_44556677_8899AABB_CCDDEEFF with `out_ready` = 1:
  - Words appear in order 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF.
  - `out_last` is high only on the fourth word.
  - `fifo_ren` pulses exactly once.
  - `busy` falls after the fourth word.
- Two blocks queued, `out_ready` = 1: 8 consecutive valid cycles with no gap, and the second `fifo_ren` coincides with the first block's last handshake.
- `out_ready` toggling 1,0,0,1,… (backpressure): each word is held stable while stalled, and no word is duplicated or skipped.
- Assert `resetn` low during the second word of a block:
  - `out_valid` drops immediately.
  - After release with an empty FIFO, the outputs stay at reset values.
  - A newly pushed block restarts at word 0.
- Empty FIFO with `out_ready` = 1 for 20 cycles: `fifo_ren` and `out_valid` stay 0.
- Build with `AES_UNPACK_BSWAP_EN` and the first block above: words are 0x33221100, 0x77665544, 0xBBAA9988, 0xFFEEDDCC.

Source files
------------

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES constants, unpacker FSM state type and byte-swap helper.
package aes_pkg;

  localparam int AES_BLOCK_BITS = 128;
  localparam int AES_WORD_BITS  = 32;

  typedef enum logic {
    IDLE,
    SEND
  } unpack_state_t;

  // Reverses byte order within one host word (little-endian host view).
  function automatic logic [AES_WORD_BITS-1:0] aes_bswap(input logic [AES_WORD_BITS-1:0] word);
    logic [AES_WORD_BITS-1:0] res;
    res = '0;
    for (int i = 0; i < AES_WORD_BITS / 8; i++) begin
      res[8*i +: 8] = word[AES_WORD_BITS-8-8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/aes_block_unpacker_if.sv
// rtl/aes_block_unpacker_if.sv - FIFO read port plus host word stream for the AES block unpacker.
interface aes_block_unpacker_if #(
  parameter int WBITS = 128,
  parameter int OBITS = 32
);

  logic             fifo_empty;
  logic [WBITS-1:0] fifo_rdata;
  logic             fifo_ren;
  logic             out_valid;
  logic             out_ready;
  logic [OBITS-1:0] out_data;
  logic             out_last;

  modport master (
    input  fifo_empty, fifo_rdata, out_ready,
    output fifo_ren, out_valid, out_data, out_last
  );

  modport slave (
    output fifo_empty, fifo_rdata, out_ready,
    input  fifo_ren, out_valid, out_data, out_last
  );

endinterface

// File: rtl/aes_block_unpacker.sv
// rtl/aes_block_unpacker.sv - drains 128-bit AES blocks from a show-ahead FIFO as MSW-first host words.
// Optional AES_UNPACK_BSWAP_EN: byte-reverse each host word on the output.
module aes_block_unpacker
  import aes_pkg::*;
#(
  parameter int wbits = AES_BLOCK_BITS,
  parameter int obits = AES_WORD_BITS
) (
  input  logic                  clock,
  input  logic                  resetn,
  aes_block_unpacker_if.master  bus,
  output logic                  busy
);

  localparam int N  = wbits / obits;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  unpack_state_t  state_q, state_d;
  logic [wbits-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             hs;
  logic             last_word;
  logic [obits-1:0] head_word;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.fifo_ren) state_d = SEND;
      SEND: if (hs && last_word && !bus.fifo_ren) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Reset gates the pop strobe so a non-empty FIFO is never drained while held in reset.
  always_comb begin
    bus.out_valid = (state_q == SEND);
    busy          = (state_q == SEND);
    last_word     = (state_q == SEND) && (cnt_q == CW'(N - 1));
    bus.out_last  = last_word;
    hs            = bus.out_valid && bus.out_ready;
    bus.fifo_ren  = resetn && !bus.fifo_empty &&
                    ((state_q == IDLE) || (hs && last_word));
  end

  // The final shift without reload pushes zeros to the head, so idle outputs read as zero.
  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (bus.fifo_ren) begin
      shreg_d = bus.fifo_rdata;
      cnt_d   = '0;
    end else if (hs) begin
      shreg_d = shreg_q << obits;
      cnt_d   = last_word ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign head_word = shreg_q[wbits-1 -: obits];

`ifdef AES_UNPACK_BSWAP_EN
  assign bus.out_data = obits'(aes_bswap(AES_WORD_BITS'(head_word)));
`else
  assign bus.out_data = head_word;
`endif

endmodule
